// File: rtl/x_mem_seq_2048x2_if.sv
// Loader stream, playback control and single-port memory signals of the
// 2048x2 sample-memory sequencer, bundled so the block has one bus port.
interface x_mem_seq_2048x2_if #(
  parameter int DIV_W = 8
);
  logic             i_ld_valid;
  logic [1:0]       i_ld_data;
  logic             o_ld_ready;
  logic             i_ld_clr;
  logic [10:0]      o_wr_ptr;
  logic             i_pl_en;
  logic [10:0]      i_pl_len;
  logic [DIV_W-1:0] i_pl_div;
  logic [1:0]       o_pl_data;
  logic             o_pl_valid;
  logic             o_pl_busy;
  logic [10:0]      o_mem_addr;
  logic             o_mem_we;
  logic [1:0]       o_mem_wdata;
  logic [1:0]       i_mem_rdata;

  // Environment side: host loader, playback control and the memory macro.
  modport master (
    output i_ld_valid, i_ld_data, i_ld_clr, i_pl_en, i_pl_len, i_pl_div, i_mem_rdata,
    input  o_ld_ready, o_wr_ptr, o_pl_data, o_pl_valid, o_pl_busy,
    input  o_mem_addr, o_mem_we, o_mem_wdata
  );

  modport slave (
    input  i_ld_valid, i_ld_data, i_ld_clr, i_pl_en, i_pl_len, i_pl_div, i_mem_rdata,
    output o_ld_ready, o_wr_ptr, o_pl_data, o_pl_valid, o_pl_busy,
    output o_mem_addr, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/x_mem_seq_2048x2.sv
// Arbiter/sequencer sharing the 2048x2 single-port sample memory between the
// host loader and the real-time playback engine; playback always wins.
module x_mem_seq_2048x2 #(
  parameter int DIV_W = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  x_mem_seq_2048x2_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [10:0]      rd_ptr;
  logic [10:0]      wr_ptr;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       pl_data;
  logic             pl_valid;

  logic tick;
  logic ld_ready;
  logic accept;

  // A tick owns the memory port; a write pending during reset is dropped.
  assign tick     = (state == RUN) && bus.i_pl_en && (div_cnt == '0);
  assign ld_ready = !i_rst && !tick && !bus.i_ld_clr;
  assign accept   = bus.i_ld_valid && ld_ready;

  assign bus.o_ld_ready = ld_ready;
  assign bus.o_wr_ptr   = wr_ptr;
  assign bus.o_pl_data  = pl_data;
  assign bus.o_pl_valid = pl_valid;
  assign bus.o_pl_busy  = (state == RUN);

  always_comb begin
    bus.o_mem_addr  = rd_ptr;
    bus.o_mem_we    = 1'b0;
    bus.o_mem_wdata = 2'b00;
    if (accept) begin
      bus.o_mem_addr  = wr_ptr;
      bus.o_mem_we    = 1'b1;
      bus.o_mem_wdata = bus.i_ld_data;
    end
  end

  // Playback FSM; rd_ptr past a shortened length runs on to 2047 and wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      div_cnt  <= '0;
      pl_data  <= 2'b00;
      pl_valid <= 1'b0;
    end else begin
      pl_valid <= tick;
      if (tick) begin
        pl_data <= bus.i_mem_rdata;
      end
      case (state)
        IDLE: begin
          if (bus.i_pl_en) begin
            state   <= RUN;
            rd_ptr  <= '0;
            div_cnt <= '0;
          end
        end
        RUN: begin
          if (!bus.i_pl_en) begin
            state <= IDLE;
          end else if (tick) begin
            div_cnt <= bus.i_pl_div;
            rd_ptr  <= (rd_ptr == bus.i_pl_len) ? 11'd0 : rd_ptr + 11'd1;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
    end else if (bus.i_ld_clr) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 11'd1;
    end
  end

endmodule
